// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads program memory combinationally and buffers one
// instruction for decode behind a valid/ready handshake, with redirect and halt.
module instruction_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  pm_addr,
    output logic               pm_rd,
    input  logic [INSTR_W-1:0] pm_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               halt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;
    logic                 fetch;

    // A fetch refills the buffer in the same cycle the old word is consumed.
    assign fetch = !redirect && !halt && (state_q == EMPTY || instr_ready);

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        state_d    = state_q;
        if (redirect) begin
            // Redirect wins over everything and discards the buffered word.
            pc_d    = redirect_addr;
            state_d = EMPTY;
        end else if (fetch) begin
            instr_d    = pm_data;
            instr_pc_d = pc_q;
            pc_d       = pc_q + ADDR_W'(1);
            state_d    = FULL;
        end else if (state_q == FULL && instr_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign pm_addr     = pc_q;
    assign pm_rd       = fetch && rst_n;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == FULL);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: startup, backpressure, redirect, wrap-around,
// halt and asynchronous reset, against a behavioural program memory.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pm_addr;
    logic        pm_rd;
    logic [15:0] pm_data;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        halt;

    logic [15:0] mem [65536];
    int          n_checks = 0;
    int          n_fail   = 0;

    assign pm_data = mem[pm_addr];

    always #5 clk = ~clk;

    instruction_fetch #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pm_addr      (pm_addr),
        .pm_rd        (pm_rd),
        .pm_data      (pm_data),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .halt         (halt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_addr = 16'h0; halt = 1'b0;
        tick(); tick();
        n_checks++;
        if ({instr_valid, pm_rd, pm_addr, instr, instr_pc} !== {1'b0, 1'b0, 16'h0, 16'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b rd=%b addr=%h instr=%h ipc=%h, need 0 0 0000 0000 0000",
                     instr_valid, pm_rd, pm_addr, instr, instr_pc);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({pm_rd, pm_addr} !== {1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL first_fetch: rd=%b addr=%h, need 1 0000", pm_rd, pm_addr);
        end
        tick();
        n_checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0000, 16'h1234}) begin
            n_fail++;
            $display("FAIL startup_word0: valid=%b ipc=%h instr=%h, need 1 0000 1234", instr_valid, instr_pc, instr);
        end
        tick();
        n_checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0001, 16'h5678}) begin
            n_fail++;
            $display("FAIL startup_word1: valid=%b ipc=%h instr=%h, need 1 0001 5678", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        #1;
        n_checks++;
        if (pm_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_rd_low: rd=%b, need 0", pm_rd);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({instr_valid, pm_rd, pm_addr, instr_pc, instr} !== {1'b1, 1'b0, 16'h0002, 16'h0001, 16'h5678}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b rd=%b addr=%h ipc=%h instr=%h, need 1 0 0002 0001 5678",
                         i, instr_valid, pm_rd, pm_addr, instr_pc, instr);
            end
        end
        instr_ready = 1'b1;
        tick();
        n_checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0002, mem[2]}) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ipc=%h instr=%h, need 1 0002 %h", instr_valid, instr_pc, instr, mem[2]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 3; i < 7; i++) begin
            tick();
            n_checks++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, 16'(i), mem[i]}) begin
                n_fail++;
                $display("FAIL b2b_%0d: valid=%b ipc=%h instr=%h, need 1 %h %h",
                         i, instr_valid, instr_pc, instr, 16'(i), mem[i]);
            end
        end
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_addr = 16'h0040;
        #1;
        n_checks++;
        if (pm_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_rd_low: rd=%b, need 0", pm_rd);
        end
        tick();
        redirect = 1'b0;
        #1;
        n_checks++;
        if ({instr_valid, pm_rd, pm_addr} !== {1'b0, 1'b1, 16'h0040}) begin
            n_fail++;
            $display("FAIL redir_flush: valid=%b rd=%b addr=%h, need 0 1 0040", instr_valid, pm_rd, pm_addr);
        end
        tick();
        n_checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0040, 16'hABCD}) begin
            n_fail++;
            $display("FAIL redir_target: valid=%b ipc=%h instr=%h, need 1 0040 abcd", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_addr = 16'hFFFF;
        tick();
        redirect = 1'b0;
        tick();
        n_checks++;
        if ({instr_valid, instr_pc, instr, pm_addr} !== {1'b1, 16'hFFFF, mem[16'hFFFF], 16'h0000}) begin
            n_fail++;
            $display("FAIL wrap_top: valid=%b ipc=%h instr=%h addr=%h, need 1 ffff %h 0000",
                     instr_valid, instr_pc, instr, pm_addr, mem[16'hFFFF]);
        end
        tick();
        n_checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0000, 16'h1234}) begin
            n_fail++;
            $display("FAIL wrap_zero: valid=%b ipc=%h instr=%h, need 1 0000 1234", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_halt();
        halt = 1'b1;
        #1;
        n_checks++;
        if (pm_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_rd_low: rd=%b, need 0", pm_rd);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({instr_valid, pm_rd, pm_addr, instr_pc} !== {1'b0, 1'b0, 16'h0001, 16'h0000}) begin
                n_fail++;
                $display("FAIL halt_frozen%0d: valid=%b rd=%b addr=%h ipc=%h, need 0 0 0001 0000",
                         i, instr_valid, pm_rd, pm_addr, instr_pc);
            end
        end
        halt = 1'b0;
        tick();
        n_checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0001, 16'h5678}) begin
            n_fail++;
            $display("FAIL halt_resume: valid=%b ipc=%h instr=%h, need 1 0001 5678", instr_valid, instr_pc, instr);
        end
        halt = 1'b1; redirect = 1'b1; redirect_addr = 16'h0010;
        tick();
        redirect = 1'b0;
        #1;
        n_checks++;
        if ({instr_valid, pm_rd, pm_addr} !== {1'b0, 1'b0, 16'h0010}) begin
            n_fail++;
            $display("FAIL halt_redirect: valid=%b rd=%b addr=%h, need 0 0 0010", instr_valid, pm_rd, pm_addr);
        end
        halt = 1'b0;
        tick();
        n_checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0010, mem[16'h0010]}) begin
            n_fail++;
            $display("FAIL halt_redirect_fetch: valid=%b ipc=%h instr=%h, need 1 0010 %h",
                     instr_valid, instr_pc, instr, mem[16'h0010]);
        end
    endtask

    task automatic test_async_reset();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({instr_valid, pm_rd, pm_addr, instr, instr_pc} !== {1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000}) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b rd=%b addr=%h instr=%h ipc=%h, need 0 0 0000 0000 0000",
                     instr_valid, pm_rd, pm_addr, instr, instr_pc);
        end
        #2;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0000, 16'h1234}) begin
            n_fail++;
            $display("FAIL post_reset_fetch: valid=%b ipc=%h instr=%h, need 1 0000 1234", instr_valid, instr_pc, instr);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a * 7 + 16'h0100);
        mem[16'h0000] = 16'h1234;
        mem[16'h0001] = 16'h5678;
        mem[16'h0040] = 16'hABCD;
        mem[16'hFFFF] = 16'hBEEF;
        test_reset();
        test_backpressure();
        test_back_to_back();
        test_redirect();
        test_wrap();
        test_halt();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
